// File: rtl/ps2_scancode_rx_pkg.sv
// Shared types and constants for the squares PS/2 keyboard receive path.
package squares_ps2_pkg;

   localparam int unsigned PS2_DATA_BITS = 8;
   localparam logic        PS2_START_BIT = 1'b0;
   localparam logic        PS2_STOP_BIT  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   // True when data bits plus parity bit carry an odd number of ones.
   function automatic logic odd_ok(input logic [PS2_DATA_BITS-1:0] b, input logic p);
      return ^{b, p};
   endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through FIFO for received scan codes; head is always on o_data.
module ps2_rx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_level == LW'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_data  = r_mem[r_rd_ptr];

   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: pin synchronisers, 11-bit frame FSM, FWFT scan-code FIFO.
// Define PS2_SCANCODE_RX_TIMEOUT_EN to abort partial frames stalled for TIMEOUT_CYCLES.
module ps2_scancode_rx
   import squares_ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic [PS2_DATA_BITS-1:0]      code_data,
   output logic                          code_valid,
   input  logic                          code_ready,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int unsigned CNT_W = $clog2(PS2_DATA_BITS);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("ps2_scancode_rx: illegal parameter value");
   end

   logic [SYNC_STAGES-1:0]   r_clk_sync;
   logic [SYNC_STAGES-1:0]   r_data_sync;
   logic                     r_clk_prev;
   logic                     w_fall;
   logic                     w_bit;

   rx_state_t                r_state;
   rx_state_t                w_state_nx;
   logic [PS2_DATA_BITS-1:0] r_shift;
   logic [PS2_DATA_BITS-1:0] w_shift_nx;
   logic [CNT_W-1:0]         r_bitcnt;
   logic [CNT_W-1:0]         w_bitcnt_nx;
   logic                     r_par;
   logic                     w_par_nx;

   logic                     w_push;
   logic                     w_pop;
   logic                     w_full;
   logic                     w_empty;
   logic                     w_timeout;
   logic                     w_perr_nx;
   logic                     w_ferr_nx;
   logic                     w_ovf_nx;
   logic                     r_parity_err;
   logic                     r_frame_err;
   logic                     r_overflow;

   // Presets of 1 model an idle bus so reset release cannot fake a falling edge.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_clk_sync  <= '1;
         r_data_sync <= '1;
         r_clk_prev  <= 1'b1;
      end else begin
         r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
         r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
         r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
      end
   end

   assign w_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
   assign w_bit  = r_data_sync[SYNC_STAGES-1];

`ifdef PS2_SCANCODE_RX_TIMEOUT_EN
   localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES);
   logic [WDOG_W-1:0] r_wdog;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset)                          r_wdog <= '0;
      else if (w_fall || r_state == ST_IDLE)    r_wdog <= '0;
      else                                      r_wdog <= r_wdog + WDOG_W'(1);
   end

   assign w_timeout = (r_state != ST_IDLE) && (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_state      <= ST_IDLE;
         r_shift      <= '0;
         r_bitcnt     <= '0;
         r_par        <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_shift      <= w_shift_nx;
         r_bitcnt     <= w_bitcnt_nx;
         r_par        <= w_par_nx;
         r_parity_err <= w_perr_nx;
         r_frame_err  <= w_ferr_nx;
         r_overflow   <= w_ovf_nx;
      end
   end

   // Frame FSM advances only on a synchronised PS/2 clock falling edge.
   always_comb begin
      w_state_nx  = r_state;
      w_shift_nx  = r_shift;
      w_bitcnt_nx = r_bitcnt;
      w_par_nx    = r_par;
      w_push      = 1'b0;
      w_perr_nx   = 1'b0;
      w_ferr_nx   = 1'b0;
      if (w_fall) begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_bit == PS2_START_BIT) begin
                  w_state_nx  = ST_DATA;
                  w_bitcnt_nx = '0;
               end
            end
            ST_DATA: begin
               w_shift_nx = {w_bit, r_shift[PS2_DATA_BITS-1:1]};
               if (r_bitcnt == CNT_W'(PS2_DATA_BITS - 1)) w_state_nx  = ST_PARITY;
               else                                       w_bitcnt_nx = r_bitcnt + CNT_W'(1);
            end
            ST_PARITY: begin
               w_par_nx   = w_bit;
               w_state_nx = ST_STOP;
            end
            ST_STOP: begin
               w_state_nx = ST_IDLE;
               if (!odd_ok(r_shift, r_par))   w_perr_nx = 1'b1;
               else if (w_bit != PS2_STOP_BIT) w_ferr_nx = 1'b1;
               else                            w_push    = 1'b1;
            end
         endcase
      end else if (w_timeout) begin
         w_state_nx  = ST_IDLE;
         w_bitcnt_nx = '0;
         w_ferr_nx   = 1'b1;
      end
   end

   ps2_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PS2_DATA_BITS)
   ) u_fifo (
      .clk     (clk_clk),
      .rst     (reset_reset),
      .i_push  (w_push),
      .i_data  (r_shift),
      .i_pop   (w_pop),
      .o_data  (code_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (fifo_level)
   );

   assign code_valid = ~w_empty;
   assign w_pop      = code_valid & code_ready;
   assign w_ovf_nx   = w_push & w_full & ~w_pop;

   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign overflow   = r_overflow;

endmodule
